// File: rtl/parity_seq_pkg.sv
// rtl/parity_seq_pkg.sv - shared FSM state type for the parity sequencer
package parity_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xor_3.sv
// rtl/xor_3.sv - three-input XOR cell
module xor_3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  // Pure combinational fold of three bits.
  always_comb begin
    y = a ^ b ^ c;
  end

endmodule

// File: rtl/parity_seq.sv
// rtl/parity_seq.sv - multi-cycle parity generator folding two bits per cycle through one xor_3
module parity_seq
  import parity_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int ODD = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_parity,
  output logic         o_busy
);

  // Counter sized to hold 0..W/2; in practice it stops at W/2-1.
  localparam int            CW      = $clog2(W / 2 + 1);
  localparam logic [CW-1:0] LAST    = CW'(W / 2 - 1);
  localparam logic          ODD_BIT = (ODD != 0);

  // The fold walks two bits per step, so an odd or tiny width has no meaning.
  if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
    $fatal(1, "parity_seq: W must be even and >= 2");
  end

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  sh;
  logic          acc;
  logic [CW-1:0] cnt;
  logic          fold;

  xor_3 m_xor (
    .a (acc),
    .b (sh[0]),
    .c (sh[1]),
    .y (fold)
  );

  // State register; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; outputs depend only on state and acc.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    o_parity  = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (cnt == LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_valid  = 1'b1;
        o_parity = acc ^ ODD_BIT;
        if (i_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: load on accept, fold and shift while running, hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sh  <= '0;
      acc <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            sh  <= i_data;
            acc <= 1'b0;
            cnt <= '0;
          end
        end
        S_RUN: begin
          acc <= fold;
          sh  <= sh >> 2;
          if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_seq.sv
// tb/tb_parity_seq.sv - scoreboard bench for parity_seq (W=8 even/odd, W=2)
module tb_parity_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // W=8 even (a) and W=8 odd (b) share stimulus; W=2 (c) has its own.
  logic       rst;
  logic       a_ivalid, a_iready;
  logic [7:0] a_data;
  logic       a_oready, a_ovalid, a_par, a_busy;
  logic       b_oready, b_ovalid, b_par, b_busy;
  logic       c_ivalid, c_iready;
  logic [1:0] c_data;
  logic       c_oready, c_ovalid, c_par, c_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_ret = 0;

  bit exp_q[$];
  bit expc_q[$];

  parity_seq #(.W(8), .ODD(0)) u_even (
    .i_clk(clk), .i_reset(rst), .i_valid(a_ivalid), .o_ready(a_oready),
    .i_data(a_data), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_parity(a_par), .o_busy(a_busy)
  );

  parity_seq #(.W(8), .ODD(1)) u_odd (
    .i_clk(clk), .i_reset(rst), .i_valid(a_ivalid), .o_ready(b_oready),
    .i_data(a_data), .o_valid(b_ovalid), .i_ready(a_iready),
    .o_parity(b_par), .o_busy(b_busy)
  );

  parity_seq #(.W(2), .ODD(0)) u_w2 (
    .i_clk(clk), .i_reset(rst), .i_valid(c_ivalid), .o_ready(c_oready),
    .i_data(c_data), .o_valid(c_ovalid), .i_ready(c_iready),
    .o_parity(c_par), .o_busy(c_busy)
  );

  always @(posedge clk) begin
    if (!rst && a_ovalid && a_iready) n_ret++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_ivalid = 1'b0; a_iready = 1'b0; a_data = 8'h00;
    c_ivalid = 1'b0; c_iready = 1'b0; c_data = 2'b00;
    tick();
    tick();
    n_cmp++;
    if ({a_oready, a_ovalid, a_par, a_busy} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_even: got %b want 1000", {a_oready, a_ovalid, a_par, a_busy});
    end
    n_cmp++;
    if ({b_oready, b_ovalid, b_par, b_busy} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_odd: got %b want 1000", {b_oready, b_ovalid, b_par, b_busy});
    end
    n_cmp++;
    if ({c_oready, c_ovalid, c_par, c_busy} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_w2: got %b want 1000", {c_oready, c_ovalid, c_par, c_busy});
    end
    rst = 1'b0;
  endtask

  // One word through the W=8 pair: latency, parity, backpressure hold, retire.
  task automatic send_a(input logic [7:0] d, input int hold, input bit noise);
    int  lat;
    bit  exp_p;
    a_data = d; a_ivalid = 1'b1; a_iready = 1'b0;
    exp_q.push_back(^d);
    tick();
    n_acc++;
    a_ivalid = 1'b0;
    lat = 0;
    while (!a_ovalid && lat < 20) begin
      n_cmp++;
      if (a_busy !== 1'b1) begin
        n_bad++; $display("FAIL busy_run: got %b want 1 at step %0d", a_busy, lat);
      end
      if (noise) begin a_ivalid = 1'($urandom); a_data = 8'($urandom); end
      tick();
      lat++;
    end
    exp_p = exp_q.pop_front();
    n_cmp++;
    if (lat !== 4) begin
      n_bad++; $display("FAIL latency: got %0d want 4 (data %h)", lat, d);
    end
    n_cmp++;
    if (a_par !== exp_p || b_par !== ~exp_p) begin
      n_bad++; $display("FAIL parity: data %h got even %b odd %b want %b/%b", d, a_par, b_par, exp_p, ~exp_p);
    end
    for (int i = 0; i < hold; i++) begin
      if (noise) begin a_ivalid = 1'($urandom); a_data = 8'($urandom); end
      tick();
      n_cmp++;
      if (a_ovalid !== 1'b1 || a_par !== exp_p || b_par !== ~exp_p || a_oready !== 1'b0) begin
        n_bad++; $display("FAIL hold: cycle %0d got v%b p%b/%b r%b want v1 p%b/%b r0", i, a_ovalid, a_par, b_par, a_oready, exp_p, ~exp_p);
      end
    end
    a_ivalid = 1'b0; a_iready = 1'b1;
    tick();
    a_iready = 1'b0;
    n_cmp++;
    if (a_oready !== 1'b1 || a_ovalid !== 1'b0 || a_par !== 1'b0) begin
      n_bad++; $display("FAIL retire: got r%b v%b p%b want r1 v0 p0", a_oready, a_ovalid, a_par);
    end
  endtask

  task automatic test_basic();
    send_a(8'hA5, 0, 1'b0);
  endtask

  task automatic test_sweep();
    logic [7:0] pats [4];
    pats[0] = 8'h00; pats[1] = 8'h07; pats[2] = 8'h80; pats[3] = 8'hFF;
    for (int i = 0; i < 4; i++) send_a(pats[i], 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_a(8'h07, 5, 1'b0);
    send_a(8'h07, 3, 1'b1);
    send_a(8'h3C, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    a_data = 8'h01; a_ivalid = 1'b1; a_iready = 1'b1;
    tick();
    a_ivalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({a_oready, a_ovalid, a_par, a_busy} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_mid: got %b want 1000", {a_oready, a_ovalid, a_par, a_busy});
    end
    a_iready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (a_ovalid !== 1'b0) begin
        n_bad++; $display("FAIL reset_no_valid: cycle %0d got %b want 0", i, a_ovalid);
      end
    end
    send_a(8'h03, 0, 1'b0);
  endtask

  task automatic test_w2();
    c_iready = 1'b1;
    c_data = 2'b01; c_ivalid = 1'b1;
    expc_q.push_back(1'b1);
    tick();
    c_ivalid = 1'b0; c_data = 2'b11;
    tick();
    n_cmp++;
    if (c_ovalid !== 1'b1 || c_par !== expc_q.pop_front()) begin
      n_bad++; $display("FAIL w2_first: got v%b p%b want v1 p1", c_ovalid, c_par);
    end
    tick();
    c_ivalid = 1'b1;
    n_cmp++;
    if (c_oready !== 1'b1) begin
      n_bad++; $display("FAIL w2_ready: got %b want 1", c_oready);
    end
    expc_q.push_back(1'b0);
    tick();
    c_ivalid = 1'b0;
    n_cmp++;
    if (c_busy !== 1'b1) begin
      n_bad++; $display("FAIL w2_busy: got %b want 1", c_busy);
    end
    tick();
    n_cmp++;
    if (c_ovalid !== 1'b1 || c_par !== expc_q.pop_front()) begin
      n_bad++; $display("FAIL w2_second: got v%b p%b want v1 p0", c_ovalid, c_par);
    end
    tick();
    c_iready = 1'b0;
  endtask

  task automatic test_random();
    int base_acc;
    int base_ret;
    base_acc = n_acc;
    base_ret = n_ret;
    for (int i = 0; i < 256; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      a_ivalid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      send_a(8'(i), int'($urandom_range(0, 2)), 1'($urandom));
    end
    n_cmp++;
    if ((n_ret - base_ret) !== (n_acc - base_acc) || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL retire_count: got %0d retires want %0d, queue left %0d",
                        n_ret - base_ret, n_acc - base_acc, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_w2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
